keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad: drives rows, senses columns, debounces, and emits a one-cycle strobe with the hex code of each new key press.
- Input-side counterpart to the dual seven-segment display controller: key_code/key_valid feed the digit registers that the display controller multiplexes out on t1/t2/seg.
- Runs on the HSOSC-derived clock (24 MHz, CLKHF_DIV 2'b01).

---
 rtl/keypad_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/keypad_scanner.sv | 143 ++++++++++++++
 tb/tb_keypad_scanner.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Hex code of each key, indexed [row][column].
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Active-low one-hot row drive for row index r.
  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; resets to all ones, the idle level of pulled-up columns.
module sync_2ff #(
  parameter int DATA_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] meta_q;
  logic [DATA_W-1:0] sync_q;

  // Capture the asynchronous input, then re-register to settle metastability.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks the rows, senses the columns, debounces press and
// release, and strobes key_valid with the hex code of each newly accepted key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 24000,
  parameter int DEBOUNCE_CYCLES = 480000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  // One shared counter serves both the row dwell and the debounce windows.
  localparam int MAX_CYCLES = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_INC   = CNT_W'(1);

  logic [3:0]       col_s;
  state_t           state_q,     state_d;
  logic [1:0]       row_idx_q,   row_idx_d;
  logic [1:0]       col_idx_q,   col_idx_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [3:0]       key_code_q,  key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q,  key_held_d;
  logic             col_any;
  logic [1:0]       col_first;
  logic             key_down;

  sync_2ff #(.DATA_W(4)) u_col_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (col),
    .q_o   (col_s)
  );

  // Find the lowest-numbered active (low) column of the driven row.
  always_comb begin
    col_first = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_s[i]) col_first = 2'(i);
    end
  end

  assign col_any  = ~&col_s;
  assign key_down = ~col_s[col_idx_q];

  // Scan/debounce/hold/release sequencing and output generation.
  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (col_any) begin
            col_idx_d = col_first;
            state_d   = DEBOUNCE;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_INC;
        end
      end
      DEBOUNCE: begin
        if (!key_down) begin
          // Bounce or glitch: rescan the same row from the start.
          state_d = SCAN;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = HELD;
          cnt_d       = '0;
          key_code_d  = KEY_MAP[row_idx_q][col_idx_q];
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_INC;
        end
      end
      HELD: begin
        if (!key_down) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        if (key_down) begin
          // Release bounce: key still counts as held, no new strobe.
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d    = SCAN;
          cnt_d      = '0;
          row_idx_d  = row_idx_q + 2'd1;
          key_held_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_INC;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      row_idx_q   <= 2'd0;
      col_idx_q   <= 2'd0;
      cnt_q       <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign row       = row_drive(row_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a keypad model that shorts the
// driven row to the columns of pressed keys.
module tb_keypad_scanner;

  localparam int SCAN = 4;
  localparam int DEB  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] key_down;

  int errors  = 0;
  int checks  = 0;
  int strobes = 0;
  logic prev_vld = 1'b0;
  logic [3:0] exp_q[$];

  typedef struct {
    int         k;
    logic [3:0] row;
    logic       held;
  } vec_t;
  vec_t vecs[9];

  always #5 clk = ~clk;

  // Keypad model: key (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  keypad_scanner #(.SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .reset     (reset),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and score any strobe against the queue.
  task automatic tick();
    logic [3:0] e;
    @(negedge clk);
    if (key_valid === 1'b1) begin
      strobes++;
      checks++;
      if (prev_vld) begin
        errors++;
        $display("FAIL strobe_width: key_valid high on consecutive cycles");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: got code %0h, none expected", key_code);
      end else begin
        e = exp_q.pop_front();
        if (key_code !== e) begin
          errors++;
          $display("FAIL strobe_code: got %0h expected %0h", key_code, e);
        end
      end
    end
    prev_vld = (key_valid === 1'b1);
  endtask

  task automatic wait_strobe(input string name, input int budget);
    int s0 = strobes;
    int n  = 0;
    while (strobes == s0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, strobes - s0, 1);
  endtask

  task automatic wait_held_low(input string name, input int budget);
    int n = 0;
    while (key_held !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, key_held, 1'b0);
  endtask

  task automatic wait_row(input string name, input logic [3:0] target, input int budget);
    int n = 0;
    while (row !== target && n < budget) begin
      tick();
      n++;
    end
    chk(name, row, target);
  endtask

  initial begin
    int cyc;
    int s0;
    vecs[0] = '{0,  4'b1110, 1'b0};
    vecs[1] = '{3,  4'b1110, 1'b0};
    vecs[2] = '{4,  4'b1101, 1'b0};
    vecs[3] = '{7,  4'b1101, 1'b0};
    vecs[4] = '{8,  4'b1011, 1'b0};
    vecs[5] = '{12, 4'b0111, 1'b0};
    vecs[6] = '{15, 4'b0111, 1'b0};
    vecs[7] = '{16, 4'b1110, 1'b0};
    vecs[8] = '{20, 4'b1101, 1'b0};

    reset    = 1'b1;
    key_down = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_row", row, 4'b1110);
    chk("rst_code", key_code, 4'h0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_held", key_held, 1'b0);
    reset = 1'b0;

    // Idle scanning: rows rotate every SCAN cycles, no strobes.
    cyc = 0;
    foreach (vecs[i]) begin
      while (cyc < vecs[i].k) begin
        tick();
        cyc++;
      end
      chk($sformatf("idle_row_k%0d", vecs[i].k), row, vecs[i].row);
      chk($sformatf("idle_held_k%0d", vecs[i].k), key_held, vecs[i].held);
    end
    while (cyc < 40) begin
      tick();
      cyc++;
    end
    chk("idle_no_strobe", strobes, 0);

    // Clean press of 9 (r2,c2) held for 50 cycles.
    exp_q.push_back(4'h9);
    key_down[2*4+2] = 1'b1;
    wait_strobe("strobe_9", 60);
    chk("held_at_strobe_9", key_held, 1'b1);
    repeat (50) tick();
    chk("held_during_9", key_held, 1'b1);
    key_down[2*4+2] = 1'b0;
    repeat (10) tick();
    chk("held_rel9_k10", key_held, 1'b1);
    tick();
    chk("held_rel9_k11", key_held, 1'b0);
    chk("code_keeps_9", key_code, 4'h9);

    // Bouncy press of A (r0,c3): 3-cycle toggles, then stable.
    s0 = strobes;
    exp_q.push_back(4'hA);
    for (int i = 0; i < 5; i++) begin
      key_down[0*4+3] = (i % 2 == 0);
      repeat (3) tick();
    end
    chk("no_strobe_bounce_A", strobes - s0, 0);
    key_down[0*4+3] = 1'b1;
    wait_strobe("strobe_A", 100);
    key_down[0*4+3] = 1'b0;
    wait_held_low("release_A", 60);

    // Five-cycle glitch on c1 while row 3 is driven.
    wait_row("reach_row3", 4'b0111, 40);
    s0 = strobes;
    key_down[3*4+1] = 1'b1;
    repeat (5) tick();
    key_down[3*4+1] = 1'b0;
    repeat (6) tick();
    chk("glitch_row_k11", row, 4'b0111);
    tick();
    chk("glitch_row_k12", row, 4'b1110);
    chk("glitch_no_strobe", strobes - s0, 0);
    chk("glitch_code_kept", key_code, 4'hA);

    // Hold 5, press F as well, release 5: F follows after release debounce.
    exp_q.push_back(4'h5);
    key_down[1*4+1] = 1'b1;
    wait_strobe("strobe_5", 100);
    s0 = strobes;
    exp_q.push_back(4'hF);
    key_down[3*4+2] = 1'b1;
    repeat (20) tick();
    chk("F_ignored_while_5", strobes - s0, 0);
    key_down[1*4+1] = 1'b0;
    wait_strobe("strobe_F", 100);
    chk("code_F", key_code, 4'hF);
    key_down[3*4+2] = 1'b0;
    wait_held_low("release_F", 60);

    // Release bounce on 0 (r3,c1).
    exp_q.push_back(4'h0);
    key_down[3*4+1] = 1'b1;
    wait_strobe("strobe_0", 100);
    s0 = strobes;
    repeat (5) tick();
    key_down[3*4+1] = 1'b0;
    repeat (2) tick();
    key_down[3*4+1] = 1'b1;
    repeat (2) tick();
    key_down[3*4+1] = 1'b0;
    repeat (10) tick();
    chk("held_rel0_k10", key_held, 1'b1);
    tick();
    chk("held_rel0_k11", key_held, 1'b0);
    chk("no_second_strobe_0", strobes - s0, 0);

    // Asynchronous reset while a key is held.
    exp_q.push_back(4'h1);
    key_down[0] = 1'b1;
    wait_strobe("strobe_1", 100);
    repeat (3) tick();
    chk("held_before_reset", key_held, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_row", row, 4'b1110);
    chk("async_rst_code", key_code, 4'h0);
    chk("async_rst_held", key_held, 1'b0);
    chk("async_rst_valid", key_valid, 1'b0);
    key_down = 16'h0;
    tick();
    reset = 1'b0;
    s0 = strobes;
    repeat (20) tick();
    chk("post_reset_no_strobe", strobes - s0, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
